mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences MEM-stage loads/stores onto the sram-like data bus (req/addr_ok/data_ok).
//  Checks alignment (raises adel/ades) and builds size/strobe/replicated write data.
//  Stalls the pipeline until the access completes; latches the raw read word for the
//  W-stage load extractor. Absorbs flushes, including flushes that arrive mid-transaction.
// PARAMETERS
//  ADDR_WIDTH   32   width of addr / data_addr
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  mem_en        in   1   valid load/store in MEM stage
//  op            in   8   alucontrolM; `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP from defines.vh
//  addr          in   AW  effective address (aluoutM)
//  wdata         in   32  store source (rt)
//  flush         in   1   exception/flush of MEM stage this cycle
//  advance       in   1   MEM->W register loads this cycle
//  data_req      out  1   bus request
//  data_wr       out  1   1=store, 0=load
//  data_size     out  2   0=byte 1=half 2=word
//  data_wstrb    out  4   byte-lane enables (0000 for loads)
//  data_addr     out  AW  bus address (= addr, unmodified)
//  data_wdata    out  32  lane-replicated store data
//  data_addr_ok  in   1   request accepted
//  data_data_ok  in   1   data returned / write done
//  data_rdata    in   32  raw read word
//  rdata         out  32  latched raw read word
//  adel          out  1   load address error
//  ades          out  1   store address error
//  stall         out  1   hold pipeline
//  done          out  1   access complete, rdata valid
// BEHAVIOUR
//  - Misalign: LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0; bytes never. adel/ades are
//    combinational, = mem_en & misaligned & ~flush. Misaligned ops issue no request
//    and do not stall.
//  - Store data: SB {4{wdata[7:0]}}, wstrb = 0001<<addr[1:0];
//    SH {2{wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011; SW wdata, wstrb = 1111.
//  - FSM states: IDLE, REQ, WAIT, DONE, ABORT. Reset: state=IDLE; rdata=0; all outputs 0.
//  - IDLE: on go = mem_en & ~misaligned & ~flush -> REQ; data_req is driven the same
//    cycle (combinational from inputs).
//  - REQ: data_req=1; bus fields are registered at entry and held stable.
//      addr_ok & data_ok in the same cycle -> DONE and capture rdata.
//      addr_ok alone -> WAIT.
//      flush without addr_ok -> IDLE (request withdrawn).
//      flush with addr_ok -> ABORT.
//  - WAIT: data_req=0. data_ok -> DONE, rdata <= data_rdata (loads only).
//      flush -> ABORT; if data_ok arrives in the same cycle -> IDLE and data is dropped.
//  - ABORT: wait for data_ok, drop the data, -> IDLE. No new request is issued while
//    in ABORT.
//  - DONE: done=1, rdata held, stall=0. advance or flush -> IDLE. DONE never re-issues,
//    even though mem_en stays high.
//  - stall = (IDLE & go) | REQ | WAIT | ABORT-with-new-mem_en. Min load latency: data_ok
//    in cycle N -> stall low, done high in cycle N+1.
//  - A single outstanding transaction at all times. addr_ok is ignored outside REQ;
//    data_ok is ignored in IDLE/DONE.
//  - rst in any state -> IDLE next edge; an in-flight bus response after reset is ignored.
// TESTING
//  1. LW addr=0x100, addr_ok c1, data_ok c3 rdata=0xDEADBEEF -> req c0-c1; stall c0-c3;
//     c4 done=1, rdata=0xDEADBEEF.
//  2. SB addr=0x103 wdata=0x12345678 -> data_wdata=0x78787878, wstrb=1000, size=0, wr=1.
//  3. LH addr=0x101 -> adel=1, data_req=0, stall=0; SW addr=0x102 -> ades=1, no req.
//  4. LW, flush in REQ before addr_ok -> req drops next cycle, state IDLE, no done.
//  5. LW accepted, flush in WAIT, data_ok 2 cycles later -> ABORT, data dropped,
//     rdata unchanged; a new mem_en is stalled until IDLE.
//  6. DONE with advance=0 for 3 cycles -> no second req, rdata stable; rst mid-WAIT ->
//     IDLE, outputs 0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: sram-like data bus between the MEM-stage access controller
// (master) and the data memory / cache (slave).
//   data_req      master->slave  bus request
//   data_wr       master->slave  1=store, 0=load
//   data_size     master->slave  0=byte 1=half 2=word
//   data_wstrb    master->slave  byte-lane enables
//   data_addr     master->slave  byte address
//   data_wdata    master->slave  lane-replicated store data
//   data_addr_ok  slave->master  request accepted
//   data_data_ok  slave->master  data returned / write done
//   data_rdata    slave->master  raw read word
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [3:0]            data_wstrb;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [31:0]           data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto the sram-like data bus.
// Checks alignment (adel/ades), builds size/strobe/replicated store data, stalls the
// pipeline until the access completes and latches the raw read word for the W stage.
// Flushes are absorbed at any point, including with a transaction in flight.
//   clk, rst       clock, synchronous active-high reset
//   mem_en         valid load/store in MEM
//   op             ALU control code selecting LB/LBU/LH/LHU/LW/SB/SH/SW
//   addr, wdata    effective address, store source
//   flush          MEM stage flushed this cycle
//   advance        MEM->W register loads this cycle
//   bus            data bus (master side)
//   rdata          latched raw read word
//   adel, ades     load / store address error (combinational)
//   stall          hold pipeline
//   done           access complete, rdata valid
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic [7:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  flush,
  input  logic                  advance,
  mem_access_ctrl_if.master     bus,
  output logic [31:0]           rdata,
  output logic                  adel,
  output logic                  ades,
  output logic                  stall,
  output logic                  done
);

  // Encodings as in defines.vh.
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t                state_q;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic [3:0]            wstrb_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;

  logic       is_ld, is_st, misaligned, go, idle_go;
  logic [1:0] size_c;
  logic [3:0] wstrb_c;
  logic [31:0] wdata_c;

  always_comb begin
    is_ld   = 1'b0;
    is_st   = 1'b0;
    size_c  = 2'd0;
    wstrb_c = 4'b0000;
    wdata_c = '0;
    unique case (op)
      EXE_LB_OP, EXE_LBU_OP: begin is_ld = 1'b1; size_c = 2'd0; end
      EXE_LH_OP, EXE_LHU_OP: begin is_ld = 1'b1; size_c = 2'd1; end
      EXE_LW_OP:             begin is_ld = 1'b1; size_c = 2'd2; end
      EXE_SB_OP: begin
        is_st   = 1'b1;
        size_c  = 2'd0;
        wstrb_c = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      EXE_SH_OP: begin
        is_st   = 1'b1;
        size_c  = 2'd1;
        wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      EXE_SW_OP: begin
        is_st   = 1'b1;
        size_c  = 2'd2;
        wstrb_c = 4'b1111;
        wdata_c = wdata;
      end
      default: ;
    endcase
  end

  assign misaligned = ((size_c == 2'd1) && addr[0]) ||
                      ((size_c == 2'd2) && (addr[1:0] != 2'b00));

  assign adel    = mem_en & is_ld & misaligned & ~flush;
  assign ades    = mem_en & is_st & misaligned & ~flush;
  assign go      = mem_en & (is_ld | is_st) & ~misaligned & ~flush;
  assign idle_go = (state_q == S_IDLE) & go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q <= S_REQ;
            wr_q    <= is_st;
            size_q  <= size_c;
            wstrb_q <= wstrb_c;
            addr_q  <= addr;
            wdata_q <= wdata_c;
          end
        end
        S_REQ: begin
          if (flush) begin
            // Accepted-and-completed under flush needs no ABORT: nothing left in flight.
            if (bus.data_addr_ok && !bus.data_data_ok) state_q <= S_ABORT;
            else                                       state_q <= S_IDLE;
          end else if (bus.data_addr_ok) begin
            if (bus.data_data_ok) begin
              state_q <= S_DONE;
              if (!wr_q) rdata_q <= bus.data_rdata;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.data_data_ok) begin
            if (flush) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DONE;
              if (!wr_q) rdata_q <= bus.data_rdata;
            end
          end else if (flush) begin
            state_q <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (bus.data_data_ok) state_q <= S_IDLE;
        end
        S_DONE: begin
          if (advance || flush) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request goes out in the same cycle as go; from REQ onward the registered copy
  // keeps the bus fields stable regardless of what the pipeline presents.
  assign bus.data_req   = idle_go | (state_q == S_REQ);
  assign bus.data_wr    = idle_go ? is_st   : wr_q;
  assign bus.data_size  = idle_go ? size_c  : size_q;
  assign bus.data_wstrb = idle_go ? wstrb_c : wstrb_q;
  assign bus.data_addr  = idle_go ? addr    : addr_q;
  assign bus.data_wdata = idle_go ? wdata_c : wdata_q;

  assign stall = idle_go | (state_q == S_REQ) | (state_q == S_WAIT) |
                 ((state_q == S_ABORT) & mem_en);
  assign done  = (state_q == S_DONE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam logic [7:0] LW = 8'b1110_0011;
  localparam logic [7:0] LH = 8'b1110_0001;
  localparam logic [7:0] SB = 8'b1110_1000;
  localparam logic [7:0] SH = 8'b1110_1001;
  localparam logic [7:0] SW = 8'b1110_1011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_en, flush, advance;
  logic [7:0]  op;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        adel, ades, stall, done;

  mem_access_ctrl_if #(.ADDR_WIDTH(32)) bus_if ();

  mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_en  (mem_en),
    .op      (op),
    .addr    (addr),
    .wdata   (wdata),
    .flush   (flush),
    .advance (advance),
    .bus     (bus_if),
    .rdata   (rdata),
    .adel    (adel),
    .ades    (ades),
    .stall   (stall),
    .done    (done)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] done_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic req_t mk(input logic w, input logic [1:0] s, input logic [3:0] st,
                              input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.wr = w; r.size = s; r.wstrb = st; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares each new bus request and each completion against the scoreboard.
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;
  req_t r;
  logic [31:0] d;
  always @(negedge clk) begin
    if (bus_if.data_req && !prev_req) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req actual=addr %h required=no request", bus_if.data_addr);
      end else begin
        r = req_q.pop_front();
        chk("req_wr",    {31'd0, bus_if.data_wr},    {31'd0, r.wr});
        chk("req_size",  {30'd0, bus_if.data_size},  {30'd0, r.size});
        chk("req_wstrb", {28'd0, bus_if.data_wstrb}, {28'd0, r.wstrb});
        chk("req_addr",  bus_if.data_addr,           r.addr);
        chk("req_wdata", bus_if.data_wdata,          r.wdata);
      end
    end
    if (done && !prev_done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=done rdata %h required=no completion", rdata);
      end else begin
        d = done_q.pop_front();
        chk("done_rdata", rdata, d);
      end
    end
    prev_req  <= bus_if.data_req;
    prev_done <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_en = 1'b0; op = 8'h00; addr = '0; wdata = '0; flush = 1'b0; advance = 1'b0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req",   {31'd0, bus_if.data_req}, 32'd0);
    chk("rst_addr",  bus_if.data_addr, 32'h0);

    // LW 0x100, addr_ok c1, data_ok c3
    tick(); mem_en = 1'b1; op = LW; addr = 32'h100; #1;
    req_q.push_back(mk(1'b0, 2'd2, 4'b0000, 32'h100, 32'h0));
    done_q.push_back(32'hDEADBEEF);
    chk("lw_c0_req",   {31'd0, bus_if.data_req}, 32'd1);
    chk("lw_c0_stall", {31'd0, stall}, 32'd1);
    tick(); bus_if.data_addr_ok = 1'b1; #1;
    chk("lw_c1_req",   {31'd0, bus_if.data_req}, 32'd1);
    chk("lw_c1_stall", {31'd0, stall}, 32'd1);
    tick(); bus_if.data_addr_ok = 1'b0; #1;
    chk("lw_c2_req",   {31'd0, bus_if.data_req}, 32'd0);
    chk("lw_c2_stall", {31'd0, stall}, 32'd1);
    tick(); bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'hDEADBEEF; #1;
    chk("lw_c3_stall", {31'd0, stall}, 32'd1);
    chk("lw_c3_done",  {31'd0, done},  32'd0);
    tick(); bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0; #1;
    chk("lw_c4_done",  {31'd0, done},  32'd1);
    chk("lw_c4_stall", {31'd0, stall}, 32'd0);
    chk("lw_c4_rdata", rdata, 32'hDEADBEEF);
    advance = 1'b1;
    tick(); idle_in(); #1;
    chk("lw_c5_done", {31'd0, done}, 32'd0);

    // SB 0x103, accepted and completed in one cycle; fields must stay registered
    tick(); mem_en = 1'b1; op = SB; addr = 32'h103; wdata = 32'h12345678; #1;
    req_q.push_back(mk(1'b1, 2'd0, 4'b1000, 32'h103, 32'h78787878));
    done_q.push_back(32'hDEADBEEF);
    tick(); addr = 32'h0; wdata = 32'h0;
    bus_if.data_addr_ok = 1'b1; bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'h11111111; #1;
    chk("sb_hold_addr",  bus_if.data_addr,  32'h103);
    chk("sb_hold_wdata", bus_if.data_wdata, 32'h78787878);
    tick(); bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0; #1;
    chk("sb_done", {31'd0, done}, 32'd1);
    advance = 1'b1;
    tick(); idle_in();

    // SH 0x102 -> upper half lanes
    tick(); mem_en = 1'b1; op = SH; addr = 32'h102; wdata = 32'hAAAABBBB; #1;
    req_q.push_back(mk(1'b1, 2'd1, 4'b1100, 32'h102, 32'hBBBBBBBB));
    done_q.push_back(32'hDEADBEEF);
    tick(); bus_if.data_addr_ok = 1'b1; #1;
    tick(); bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b1; #1;
    chk("sh_wait_stall", {31'd0, stall}, 32'd1);
    tick(); bus_if.data_data_ok = 1'b0; #1;
    chk("sh_done", {31'd0, done}, 32'd1);
    advance = 1'b1;
    tick(); idle_in();

    // Misaligned accesses
    tick(); mem_en = 1'b1; op = LH; addr = 32'h101; #1;
    chk("lh_adel",  {31'd0, adel},  32'd1);
    chk("lh_ades",  {31'd0, ades},  32'd0);
    chk("lh_req",   {31'd0, bus_if.data_req}, 32'd0);
    chk("lh_stall", {31'd0, stall}, 32'd0);
    flush = 1'b1; #1;
    chk("lh_flush_adel", {31'd0, adel}, 32'd0);
    tick(); flush = 1'b0; op = SW; addr = 32'h102; #1;
    chk("sw_ades",  {31'd0, ades},  32'd1);
    chk("sw_adel",  {31'd0, adel},  32'd0);
    chk("sw_req",   {31'd0, bus_if.data_req}, 32'd0);
    chk("sw_stall", {31'd0, stall}, 32'd0);
    tick(); idle_in(); #1;
    chk("mis_done", {31'd0, done}, 32'd0);

    // Flush in REQ before addr_ok
    tick(); mem_en = 1'b1; op = LW; addr = 32'h200; #1;
    req_q.push_back(mk(1'b0, 2'd2, 4'b0000, 32'h200, 32'h0));
    tick(); flush = 1'b1; #1;
    chk("fl_req_held", {31'd0, bus_if.data_req}, 32'd1);
    tick(); idle_in(); #1;
    chk("fl_req_drop", {31'd0, bus_if.data_req}, 32'd0);
    chk("fl_stall",    {31'd0, stall}, 32'd0);
    tick(); #1;
    chk("fl_done", {31'd0, done}, 32'd0);

    // Flush in WAIT, late data dropped, next load held off until IDLE
    tick(); mem_en = 1'b1; op = LW; addr = 32'h300; #1;
    req_q.push_back(mk(1'b0, 2'd2, 4'b0000, 32'h300, 32'h0));
    tick(); bus_if.data_addr_ok = 1'b1; #1;
    tick(); bus_if.data_addr_ok = 1'b0; flush = 1'b1; #1;
    chk("ab_wait_stall", {31'd0, stall}, 32'd1);
    tick(); flush = 1'b0; addr = 32'h304; #1;
    chk("ab_stall", {31'd0, stall}, 32'd1);
    chk("ab_req",   {31'd0, bus_if.data_req}, 32'd0);
    tick(); bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'h55555555; #1;
    chk("ab_drop_stall", {31'd0, stall}, 32'd1);
    chk("ab_drop_req",   {31'd0, bus_if.data_req}, 32'd0);
    chk("ab_drop_done",  {31'd0, done}, 32'd0);
    tick(); bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0; #1;
    req_q.push_back(mk(1'b0, 2'd2, 4'b0000, 32'h304, 32'h0));
    done_q.push_back(32'hCAFEF00D);
    chk("ab_new_req",    {31'd0, bus_if.data_req}, 32'd1);
    chk("ab_rdata_kept", rdata, 32'hDEADBEEF);
    tick(); bus_if.data_addr_ok = 1'b1; bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'hCAFEF00D; #1;
    chk("nx_stall", {31'd0, stall}, 32'd1);
    tick(); bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0; #1;
    chk("nx_done",  {31'd0, done},  32'd1);
    chk("nx_stall_low", {31'd0, stall}, 32'd0);

    // DONE held with advance=0 while mem_en stays high
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("hold_done",  {31'd0, done}, 32'd1);
      chk("hold_req",   {31'd0, bus_if.data_req}, 32'd0);
      chk("hold_rdata", rdata, 32'hCAFEF00D);
    end
    advance = 1'b1;
    tick(); idle_in(); #1;
    chk("hold_exit", {31'd0, done}, 32'd0);

    // Reset mid-WAIT; late response ignored
    tick(); mem_en = 1'b1; op = LW; addr = 32'h400; #1;
    req_q.push_back(mk(1'b0, 2'd2, 4'b0000, 32'h400, 32'h0));
    tick(); bus_if.data_addr_ok = 1'b1; #1;
    tick(); bus_if.data_addr_ok = 1'b0; mem_en = 1'b0; rst = 1'b1; #1;
    chk("rw_stall", {31'd0, stall}, 32'd1);
    tick(); rst = 1'b0; bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'h99999999; #1;
    chk("rw_stall0", {31'd0, stall}, 32'd0);
    chk("rw_req0",   {31'd0, bus_if.data_req}, 32'd0);
    chk("rw_done0",  {31'd0, done}, 32'd0);
    chk("rw_rdata0", rdata, 32'h0);
    chk("rw_addr0",  bus_if.data_addr, 32'h0);
    chk("rw_wr0",    {31'd0, bus_if.data_wr}, 32'd0);
    tick(); bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0; #1;
    chk("rw_late_done",  {31'd0, done}, 32'd0);
    chk("rw_late_rdata", rdata, 32'h0);

    repeat (2) tick();
    chk("sb_req_left",  req_q.size(),  32'd0);
    chk("sb_done_left", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
